jk_sync_counter: RTL and testbench

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

---
 rtl/jk_sync_counter.sv | 108 ++++++++++
 tb/tb_jk_sync_counter.sv | 112 +++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MOD up/down counter whose next state is produced
// through per-bit JK excitation. j/k are exported for a downstream JK stage,
// tc flags the wrap point of the active count direction, and load_err pulses
// for one cycle after a load value outside 0..MOD-1 was rejected.
module jk_sync_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             load_err
);

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_COUNT,
        CMD_LOAD,
        CMD_CLR
    } cmd_t;

    // The modulus may equal 2^WIDTH, so the load range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] target;
    logic             load_ok;
    cmd_t             cmd;

    // Resolve the command (clr > load > en > hold) and derive the excitation.
    always_comb begin
        cmd        = CMD_HOLD;
        target     = q_q;
        load_ok    = ({1'b0, d} < MOD_W);
        j          = '0;
        k          = '0;
        tc         = 1'b0;
        load_err_d = 1'b0;

        if (clr) begin
            cmd = CMD_CLR;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (en) begin
            cmd = CMD_COUNT;
        end

        // Out-of-range states fall into the wrap branch in both directions.
        if (up_dn) begin
            target = (q_q < MAX_V) ? q_q + WIDTH'(1) : '0;
        end else begin
            target = (q_q == '0 || q_q > MAX_V) ? MAX_V : q_q - WIDTH'(1);
        end

        unique case (cmd)
            CMD_CLR: begin
                j = '0;
                k = '1;
            end
            CMD_LOAD: begin
                if (load_ok) begin
                    j = d;
                    k = ~d;
                end else begin
                    j          = '0;
                    k          = '1;
                    load_err_d = 1'b1;
                end
            end
            CMD_COUNT: begin
                j  = target ^ q_q;
                k  = target ^ q_q;
                tc = up_dn ? (q_q == MAX_V) : (q_q == '0);
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase

        // Next state only via the JK characteristic equation.
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // State and error-pulse registers; clr is sampled synchronously.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q        <= '0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = q_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, MOD=10): directed
// scenarios followed by a random command sequence, all compared against an
// arithmetic mod-10 reference model.
module tb_jk_sync_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q, j, k;
    logic       tc, load_err;

    int vectors = 0;
    int miscompares = 0;

    int mq = 0;       // model counter value
    bit merr = 1'b0;  // model load_err

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .q(q), .j(j), .k(k), .tc(tc), .load_err(load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check state.
    task automatic step(input bit c, input bit e, input bit u, input bit l, input int dv);
        int ej, ek, etc, nxt, target;
        bit err;
        logic [3:0] jj, kk, qp;
        @(negedge clk);
        clr = c; en = e; up_dn = u; load = l; d = 4'(dv);
        #1;
        ej = 0; ek = 0; etc = 0; nxt = mq; err = 1'b0;
        if (c) begin
            ek = 15; nxt = 0;
        end else if (l) begin
            if (dv < 10) begin
                ej = dv; ek = 15 - dv; nxt = dv;
            end else begin
                ek = 15; nxt = 0; err = 1'b1;
            end
        end else if (e) begin
            if (u) target = (mq >= 9) ? 0 : mq + 1;
            else   target = (mq == 0 || mq > 9) ? 9 : mq - 1;
            ej = mq ^ target; ek = ej; nxt = target;
            etc = u ? (mq == 9) : (mq == 0);
        end
        chk("j", 32'(j), 32'(ej));
        chk("k", 32'(k), 32'(ek));
        chk("tc", 32'(tc), 32'(etc));
        jj = j; kk = k; qp = q;
        @(posedge clk);
        #1;
        mq = nxt; merr = err;
        chk("q", 32'(q), 32'(mq));
        chk("load_err", 32'(load_err), 32'(merr));
        chk("jk_char", 32'(q), 32'((jj & ~qp) | (~kk & qp)));
    endtask

    initial begin
        // Scenario 1: clear, then count up 12 cycles through the wrap.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
        chk("scen1_q", 32'(q), 32'd2);

        // Scenario 2: from 0 count down 9,8,7.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("scen2_q", 32'(q), 32'd7);

        // Scenario 3: load overrides enable.
        step(0, 1, 1, 1, 6);
        chk("scen3_q", 32'(q), 32'd6);

        // Scenario 4: illegal load, error pulse lasts one cycle.
        step(0, 0, 1, 1, 12);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Illegal load at the MAX data value, legal load at the boundary.
        step(0, 0, 0, 1, 15);
        step(0, 0, 0, 1, 9);
        step(0, 1, 1, 0, 0);

        // Scenario 5: clr beats load while counting up from 7.
        step(0, 0, 0, 1, 7);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 3);
        chk("scen5_q", 32'(q), 32'd0);

        // Scenario 6: random command sequence.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
